// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the sub-word memory access controller.
//   - CPU op encodings (OP_LW .. OP_SB)
//   - controller state enum (S_IDLE, S_RD, S_WR, S_RESP)
//   - small predicates on op codes
package mem_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } stateT;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Sub-word stores need a read-modify-write of the containing word.
  function automatic logic is_sub(input logic [2:0] op);
    return (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// mem_lane_unit: combinational byte-lane logic.
//   op        in  3   operation code (mem_pkg OP_*)
//   laneAddr  in  2   byte offset within the word (addr[1:0])
//   word      in  32  memory word (little-endian: byte 0 = bits 7:0)
//   wdata     in  32  CPU store data
//   loadVal   out 32  selected lane, sign/zero extended per op
//   storeWord out 32  word to write back (wdata for SW, merged word for SH/SB)
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  laneAddr,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] loadVal,
  output logic [31:0] storeWord
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [7:0]  mergedByte [4];

  always_comb begin
    byteSel = word[{laneAddr, 3'b000} +: 8];
    halfSel = word[{laneAddr[1], 4'b0000} +: 16];
    loadVal = '0;
    case (op)
      OP_LW:   loadVal = word;
      OP_LH:   loadVal = {{16{halfSel[15]}}, halfSel};
      OP_LHU:  loadVal = {16'h0000, halfSel};
      OP_LB:   loadVal = {{24{byteSel[7]}}, byteSel};
      OP_LBU:  loadVal = {24'h000000, byteSel};
      default: loadVal = '0;
    endcase
  end

  // Each byte lane independently decides whether it takes store data or keeps
  // the old memory byte. For SH, lane gi takes the half of wdata[15:0] that
  // matches its position inside the addressed halfword.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gLane
      always_comb begin
        mergedByte[gi] = word[8*gi +: 8];
        if (op == OP_SB && laneAddr == 2'(gi))
          mergedByte[gi] = wdata[7:0];
        else if (op == OP_SH && laneAddr[1] == 1'(gi / 2))
          mergedByte[gi] = wdata[8*(gi % 2) +: 8];
      end
    end
  endgenerate

  assign storeWord = (op == OP_SW) ? wdata
                   : {mergedByte[3], mergedByte[2], mergedByte[1], mergedByte[0]};

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequential sub-word load/store controller in front of a
// word-wide data memory. One request at a time; SH/SB use read-modify-write.
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-low
//   req_valid  in   1   CPU request present
//   req_ready  out  1   idle, request accepted when req_valid & req_ready
//   op         in   3   operation (mem_pkg OP_*)
//   addr       in   32  byte address
//   wdata      in   32  store data
//   pc         in   32  PC of requesting instruction
//   resp_valid out  1   one-cycle completion pulse
//   rdata      out  32  extended load data (0 for stores/errors)
//   addr_err   out  1   misaligned or out-of-range request
//   dm_addr    out  32  word address to DM
//   dm_we      out  1   DM write enable
//   dm_wd      out  32  DM write data (0 when dm_we=0)
//   dm_rd      in   32  DM combinational read data
//   dm_pc      out  32  latched pc
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic [31:0] dm_addr,
  output logic        dm_we,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd,
  output logic [31:0] dm_pc
);

  stateT       stateReg, stateNext;
  logic [2:0]  opReg;
  logic [31:0] addrReg, wdataReg, pcReg, wordReg, rdataReg;
  logic        errReg;

  logic        accept;
  logic        misaligned, addrBad;
  logic [31:0] laneWord, loadVal, storeWord;

  assign accept = req_valid && (stateReg == S_IDLE);

  always_comb begin
    misaligned = 1'b0;
    case (op)
      OP_LW, OP_SW:          misaligned = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH:  misaligned = addr[0];
      default:               misaligned = 1'b0;
    endcase
    addrBad = misaligned || (addr >= 32'(MEM_BYTES));
  end

  // Next-state logic; outputs are decoded directly from stateReg below.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      S_IDLE: begin
        if (req_valid) begin
          if (addrBad)           stateNext = S_RESP;
          else if (op == OP_SW)  stateNext = S_WR;
          else                   stateNext = S_RD;
        end
      end
      S_RD:    stateNext = is_sub(opReg) ? S_WR : S_RESP;
      S_WR:    stateNext = S_RESP;
      S_RESP:  stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stateReg <= S_IDLE;
    else        stateReg <= stateNext;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opReg    <= OP_LW;
      addrReg  <= '0;
      wdataReg <= '0;
      pcReg    <= '0;
      wordReg  <= '0;
      rdataReg <= '0;
      errReg   <= 1'b0;
    end else begin
      if (accept) begin
        opReg    <= op;
        addrReg  <= addr;
        wdataReg <= wdata;
        pcReg    <= pc;
        rdataReg <= '0;       // stores and errors report zero data
        errReg   <= addrBad;
      end
      if (stateReg == S_RD) begin
        wordReg <= dm_rd;
        if (!is_store(opReg)) rdataReg <= loadVal;
      end
    end
  end

  // In RD the lane unit extracts from the live DM word; in WR it merges into
  // the word captured during RD.
  assign laneWord = (stateReg == S_RD) ? dm_rd : wordReg;

  mem_lane_unit uLane (
    .op        (opReg),
    .laneAddr  (addrReg[1:0]),
    .word      (laneWord),
    .wdata     (wdataReg),
    .loadVal   (loadVal),
    .storeWord (storeWord)
  );

  // dm_we is decoded from state so an asynchronous reset drops it at once.
  assign req_ready  = (stateReg == S_IDLE);
  assign resp_valid = (stateReg == S_RESP);
  assign dm_we      = (stateReg == S_WR);
  assign dm_wd      = dm_we ? storeWord : '0;
  assign dm_addr    = {addrReg[31:2], 2'b00};
  assign dm_pc      = pcReg;
  assign rdata      = rdataReg;
  assign addr_err   = errReg;

endmodule
